// File: rtl/mips_fetch_prefetch_queue.sv
`timescale 1ns/1ps
// Fetch front end: sequential PC generation, pipelined imem request issue and an
// in-order instruction queue to decode. Optional FETCH_BYPASS_EN forwards responses to decode when the queue is empty.
module mips_fetch_prefetch_queue #(
  parameter int                    Data_Width = 32,
  parameter int                    Depth      = 4,
  parameter logic [Data_Width-1:0] Reset_PC   = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_fetch_en,
  output logic                         o_imem_req_valid,
  input  logic                         i_imem_req_ready,
  output logic [Data_Width-1:0]        o_imem_req_addr,
  input  logic                         i_imem_rsp_valid,
  input  logic [Data_Width-1:0]        i_imem_rsp_data,
  output logic                         o_inst_valid,
  input  logic                         i_inst_ready,
  output logic [Data_Width-1:0]        o_inst_data,
  output logic [Data_Width-1:0]        o_inst_pc,
  input  logic                         i_redirect_valid,
  input  logic [Data_Width-1:0]        i_redirect_addr,
  output logic [$clog2(Depth+1)-1:0]   o_q_count
);

  localparam int CW = $clog2(Depth + 1);
  localparam int AW = $clog2(Depth);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(Depth);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [Data_Width-1:0] r_fetch_pc;
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         r_discard;
  logic [CW-1:0]         r_count;
  logic [AW-1:0]         r_head;
  logic [AW-1:0]         r_tail;
  logic [AW-1:0]         r_pf_head;
  logic [AW-1:0]         r_pf_tail;
  logic [Data_Width-1:0] r_q_data [Depth];
  logic [Data_Width-1:0] r_q_pc   [Depth];
  logic [Data_Width-1:0] r_pf_pc  [Depth];

  logic                  w_accept;
  logic                  w_rsp;
  logic                  w_drop;
  logic                  w_bypass;
  logic                  w_bypass_take;
  logic                  w_push;
  logic                  w_pop;
  logic [Data_Width-1:0] w_rsp_pc;
  logic [CW:0]           w_inflight;
  logic [CW-1:0]         w_discard_calc;

  assign w_accept   = o_imem_req_valid & i_imem_req_ready;
  assign w_rsp      = i_imem_rsp_valid;
  assign w_rsp_pc   = r_pf_pc[r_pf_head];
  assign w_drop     = w_rsp & ((r_discard != '0) | i_redirect_valid);
  assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding};

  // Responses still owed by the memory at the moment of a redirect are stale.
  assign w_discard_calc = r_outstanding + CW'(w_accept) - CW'(w_rsp);

`ifdef FETCH_BYPASS_EN
  assign w_bypass = (r_count == '0) && (r_discard == '0) && w_rsp && !i_redirect_valid;
`else
  assign w_bypass = 1'b0;
`endif
  assign w_bypass_take = w_bypass & i_inst_ready;

  assign w_push = w_rsp & ~w_drop & ~w_bypass_take;
  assign w_pop  = (r_count != '0) & i_inst_ready & ~i_redirect_valid;

  // Credit: queued entries plus in-flight requests never exceed the queue size.
  assign o_imem_req_valid = (r_state == S_RUN) & i_fetch_en & ~i_redirect_valid &
                            (w_inflight < DEPTH_W);
  assign o_imem_req_addr  = r_fetch_pc;
  assign o_q_count        = r_count;

  always_comb begin
    o_inst_valid = (r_count != '0);
    o_inst_data  = '0;
    o_inst_pc    = '0;
    if (r_count != '0) begin
      o_inst_data = r_q_data[r_head];
      o_inst_pc   = r_q_pc[r_head];
    end else if (w_bypass) begin
      o_inst_valid = 1'b1;
      o_inst_data  = i_imem_rsp_data;
      o_inst_pc    = w_rsp_pc;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_redirect_valid) begin
      if (w_discard_calc != '0) begin
        w_state_nxt = S_FLUSH;
      end else begin
        w_state_nxt = i_fetch_en ? S_RUN : S_IDLE;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_fetch_en) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (!i_fetch_en) w_state_nxt = S_IDLE;
        end
        S_FLUSH: begin
          if ((r_discard == '0) || ((r_discard == CW'(1)) && w_rsp)) begin
            w_state_nxt = i_fetch_en ? S_RUN : S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_fetch_pc    <= Reset_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp);
      // A fresh fetch session after fetch_en rises starts from Reset_PC.
      if (i_redirect_valid) begin
        r_fetch_pc <= i_redirect_addr;
      end else if ((r_state == S_IDLE) && i_fetch_en) begin
        r_fetch_pc <= Reset_PC;
      end else if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 1'b1;
      end
      if (i_redirect_valid) begin
        r_discard <= w_discard_calc;
      end else if (w_rsp && (r_discard != '0)) begin
        r_discard <= r_discard - CW'(1);
      end
    end
  end

  // Per-request PC FIFO: every response, kept or dropped, retires one entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pf_head <= '0;
      r_pf_tail <= '0;
    end else begin
      if (w_accept) r_pf_tail <= r_pf_tail + AW'(1);
      if (w_rsp)    r_pf_head <= r_pf_head + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_redirect_valid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_pf_pc[r_pf_tail] <= r_fetch_pc;
    if (w_push) begin
      r_q_data[r_tail] <= i_imem_rsp_data;
      r_q_pc[r_tail]   <= w_rsp_pc;
    end
  end

endmodule

// File: tb/tb_mips_fetch_prefetch_queue.sv
`timescale 1ns/1ps
// Randomized and directed bench for mips_fetch_prefetch_queue against an in-order
// memory model and a PC-stream scoreboard.
module tb_mips_fetch_prefetch_queue;

  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam int          CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] RPC   = 32'h0;
`ifdef FETCH_BYPASS_EN
  localparam int LAT_EXP = 1;
`else
  localparam int LAT_EXP = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_en = 1'b0;
  logic          req_valid;
  logic          req_ready = 1'b0;
  logic [DW-1:0] req_addr;
  logic          rsp_valid = 1'b0;
  logic [DW-1:0] rsp_data = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [DW-1:0] inst_data;
  logic [DW-1:0] inst_pc;
  logic          redirect_valid = 1'b0;
  logic [DW-1:0] redirect_addr = '0;
  logic [CW-1:0] q_count;

  int checks = 0;
  int errors = 0;

  mips_fetch_prefetch_queue #(.Data_Width(DW), .Depth(DEPTH), .Reset_PC(RPC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_fetch_en       (fetch_en),
    .o_imem_req_valid (req_valid),
    .i_imem_req_ready (req_ready),
    .o_imem_req_addr  (req_addr),
    .i_imem_rsp_valid (rsp_valid),
    .i_imem_rsp_data  (rsp_data),
    .o_inst_valid     (inst_valid),
    .i_inst_ready     (inst_ready),
    .o_inst_data      (inst_data),
    .o_inst_pc        (inst_pc),
    .i_redirect_valid (redirect_valid),
    .i_redirect_addr  (redirect_addr),
    .o_q_count        (q_count)
  );

  always #5 clk = ~clk;

  // Memory model: in-order responses, each at least drv_lat cycles after its accept.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t       pend[$];
  int          cyc;
  int          last_due;
  logic        prev_fen;
  logic [31:0] m_addr;
  logic [31:0] m_pc;

  logic        drv_fetch_en, drv_req_ready, drv_inst_ready, drv_redirect;
  logic [31:0] drv_redirect_addr;
  int          drv_lat;

  logic          s_req_valid, s_accept, s_rsp_valid, s_inst_valid, s_pop;
  logic [31:0]   s_req_addr, s_inst_pc, s_inst_data;
  logic [CW-1:0] s_qcount;
  logic [31:0]   e_addr, e_pc, e_data;

  function automatic logic [31:0] memf(input logic [31:0] a);
    memf = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drv_fetch_en = 1'b0; drv_req_ready = 1'b0; drv_inst_ready = 1'b0;
    drv_redirect = 1'b0; drv_redirect_addr = '0; drv_lat = 1;
    fetch_en = 1'b0; req_ready = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_addr = '0; rsp_valid = 1'b0; rsp_data = '0;
    pend.delete();
    cyc = 0; last_due = 0; prev_fen = 1'b0; m_addr = RPC; m_pc = RPC;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive at negedge, sample 1ns later, advance the model at posedge.
  task automatic cycle_step();
    pend_t p;
    @(negedge clk);
    fetch_en       = drv_fetch_en;
    req_ready      = drv_req_ready;
    inst_ready     = drv_inst_ready;
    redirect_valid = drv_redirect;
    redirect_addr  = drv_redirect_addr;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = memf(pend[0].addr);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
    end
    #1;
    s_req_valid  = req_valid;
    s_req_addr   = req_addr;
    s_accept     = req_valid & req_ready;
    s_rsp_valid  = rsp_valid;
    s_inst_valid = inst_valid;
    s_inst_pc    = inst_pc;
    s_inst_data  = inst_data;
    s_qcount     = q_count;
    s_pop        = inst_valid & inst_ready & ~redirect_valid;
    e_addr       = m_addr;
    e_pc         = m_pc;
    e_data       = memf(m_pc);
    @(posedge clk);
    if (s_rsp_valid) void'(pend.pop_front());
    if (s_accept) begin
      p.addr   = s_req_addr;
      p.due    = (cyc + drv_lat > last_due + 1) ? cyc + drv_lat : last_due + 1;
      last_due = p.due;
      pend.push_back(p);
    end
    if (drv_redirect) begin
      m_addr = drv_redirect_addr;
      m_pc   = drv_redirect_addr;
    end else begin
      if (s_accept) m_addr = m_addr + 32'd1;
      if (s_pop)    m_pc   = m_pc + 32'd1;
      if (drv_fetch_en && !prev_fen) begin
        m_addr = RPC;
        m_pc   = RPC;
      end
    end
    prev_fen = drv_fetch_en;
    cyc++;
  endtask

  task automatic test_reset();
    do_reset();
    drv_fetch_en = 1'b1; drv_req_ready = 1'b1; drv_lat = 1;
    repeat (5) cycle_step();
    #3 rst_n = 1'b0;
    #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid: got %0b expected 0", req_valid); end
    checks++; if (req_addr !== RPC) begin errors++; $display("[TB] FAIL reset_req_addr: got %0h expected %0h", req_addr, RPC); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_inst_valid: got %0b expected 0", inst_valid); end
    checks++; if (inst_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst_data: got %0h expected 0", inst_data); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst_pc: got %0h expected 0", inst_pc); end
    checks++; if (q_count !== '0) begin errors++; $display("[TB] FAIL reset_q_count: got %0d expected 0", q_count); end
  endtask

  task automatic test_sequential();
    int n_acc, n_pop, t_acc, t_val;
    do_reset();
    drv_fetch_en = 1'b1; drv_req_ready = 1'b1; drv_inst_ready = 1'b1; drv_lat = 1;
    n_acc = 0; n_pop = 0; t_acc = -1; t_val = -1;
    for (int t = 0; t < 40 && n_pop < 6; t++) begin
      cycle_step();
      if (s_accept && t_acc < 0) t_acc = t;
      if (s_inst_valid && t_val < 0) t_val = t;
      if (s_accept && n_acc < 6) begin
        checks++;
        if (s_req_addr !== 32'(n_acc)) begin errors++; $display("[TB] FAIL seq_addr: got %0h expected %0h", s_req_addr, n_acc); end
        n_acc++;
      end
      if (s_pop) begin
        checks++;
        if (s_inst_pc !== 32'(n_pop) || s_inst_data !== memf(32'(n_pop))) begin
          errors++; $display("[TB] FAIL seq_pop: got pc %0h data %0h expected pc %0h data %0h", s_inst_pc, s_inst_data, n_pop, memf(32'(n_pop)));
        end
        n_pop++;
      end
    end
    checks++; if (n_pop < 6) begin errors++; $display("[TB] FAIL seq_timeout: got %0d pops expected 6", n_pop); end
    checks++; if (t_val - t_acc != LAT_EXP) begin errors++; $display("[TB] FAIL seq_latency: got %0d expected %0d", t_val - t_acc, LAT_EXP); end
  endtask

  task automatic test_queue_full();
    int n_acc;
    do_reset();
    drv_fetch_en = 1'b1; drv_req_ready = 1'b1; drv_inst_ready = 1'b0; drv_lat = 1;
    n_acc = 0;
    repeat (15) begin
      cycle_step();
      if (s_accept) n_acc++;
    end
    checks++; if (n_acc != DEPTH) begin errors++; $display("[TB] FAIL full_accepts: got %0d expected %0d", n_acc, DEPTH); end
    checks++; if (s_qcount !== CW'(DEPTH)) begin errors++; $display("[TB] FAIL full_q_count: got %0d expected %0d", s_qcount, DEPTH); end
    checks++; if (s_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_req_valid: got %0b expected 0", s_req_valid); end
    checks++; if (s_inst_valid !== 1'b1 || s_inst_pc !== RPC) begin errors++; $display("[TB] FAIL full_head: got valid %0b pc %0h expected 1 %0h", s_inst_valid, s_inst_pc, RPC); end
  endtask

  task automatic test_redirect_inflight();
    int n_acc;
    bit got;
    do_reset();
    drv_fetch_en = 1'b1; drv_req_ready = 1'b1; drv_inst_ready = 1'b0; drv_lat = 3;
    n_acc = 0;
    for (int t = 0; t < 20 && n_acc < 2; t++) begin
      cycle_step();
      if (s_accept) n_acc++;
    end
    drv_req_ready = 1'b0; drv_redirect = 1'b1; drv_redirect_addr = 32'h40;
    cycle_step();
    checks++; if (s_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_req_gated: got %0b expected 0", s_req_valid); end
    drv_redirect = 1'b0; drv_req_ready = 1'b1; drv_inst_ready = 1'b1;
    cycle_step();
    checks++; if (s_inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_inst_valid: got %0b expected 0", s_inst_valid); end
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      cycle_step();
      if (s_pop) begin
        got = 1'b1;
        checks++;
        if (s_inst_pc !== 32'h40 || s_inst_data !== memf(32'h40)) begin
          errors++; $display("[TB] FAIL redir_first_pc: got pc %0h data %0h expected pc 40 data %0h", s_inst_pc, s_inst_data, memf(32'h40));
        end
      end
    end
    checks++; if (!got) begin errors++; $display("[TB] FAIL redir_timeout: got no pop expected one"); end
  endtask

  task automatic test_redirect_collision();
    bit ready_hit, got;
    do_reset();
    drv_fetch_en = 1'b1; drv_req_ready = 1'b1; drv_inst_ready = 1'b0; drv_lat = 1;
    ready_hit = 1'b0;
    for (int t = 0; t < 20 && !ready_hit; t++) begin
      cycle_step();
      #1;
      ready_hit = (q_count != '0) && (pend.size() > 0) && (pend[0].due <= cyc);
    end
    checks++; if (!ready_hit) begin errors++; $display("[TB] FAIL coll_setup: got no collision window expected one"); end
    drv_redirect = 1'b1; drv_redirect_addr = 32'h100; drv_inst_ready = 1'b1;
    cycle_step();
    checks++; if (s_inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL coll_head_valid: got %0b expected 1", s_inst_valid); end
    drv_redirect = 1'b0; drv_req_ready = 1'b0;
    cycle_step();
    checks++; if (s_qcount !== '0 || s_inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL coll_cleared: got count %0d valid %0b expected 0 0", s_qcount, s_inst_valid); end
    drv_req_ready = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 30 && !got; t++) begin
      cycle_step();
      if (s_pop) begin
        got = 1'b1;
        checks++;
        if (s_inst_pc !== 32'h100) begin errors++; $display("[TB] FAIL coll_first_pc: got %0h expected 100", s_inst_pc); end
      end
    end
    checks++; if (!got) begin errors++; $display("[TB] FAIL coll_timeout: got no pop expected one"); end
  endtask

  task automatic test_stall_wrap();
    int n_acc, n_pop;
    do_reset();
    drv_fetch_en = 1'b1; drv_req_ready = 1'b0; drv_inst_ready = 1'b1; drv_lat = 2;
    drv_redirect = 1'b1; drv_redirect_addr = 32'hFFFF_FFFE;
    cycle_step();
    drv_redirect = 1'b0;
    repeat (3) begin
      cycle_step();
      checks++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 32'hFFFF_FFFE) begin
        errors++; $display("[TB] FAIL stall_addr: got valid %0b addr %0h expected 1 fffffffe", s_req_valid, s_req_addr);
      end
    end
    drv_req_ready = 1'b1;
    n_acc = 0; n_pop = 0;
    for (int t = 0; t < 30 && n_pop < 3; t++) begin
      cycle_step();
      if (s_accept && n_acc < 3) begin
        checks++;
        if (s_req_addr !== 32'hFFFF_FFFE + 32'(n_acc)) begin errors++; $display("[TB] FAIL wrap_addr: got %0h expected %0h", s_req_addr, 32'hFFFF_FFFE + 32'(n_acc)); end
        n_acc++;
      end
      if (s_pop) begin
        checks++;
        if (s_inst_pc !== 32'hFFFF_FFFE + 32'(n_pop)) begin errors++; $display("[TB] FAIL wrap_pc: got %0h expected %0h", s_inst_pc, 32'hFFFF_FFFE + 32'(n_pop)); end
        n_pop++;
      end
    end
    checks++; if (n_pop < 3) begin errors++; $display("[TB] FAIL wrap_timeout: got %0d pops expected 3", n_pop); end
  endtask

  task automatic test_fetch_stop();
    bit got;
    do_reset();
    drv_fetch_en = 1'b1; drv_req_ready = 1'b1; drv_inst_ready = 1'b1; drv_lat = 2;
    repeat (6) cycle_step();
    drv_fetch_en = 1'b0;
    repeat (10) begin
      cycle_step();
      checks++; if (s_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL stop_req_valid: got %0b expected 0", s_req_valid); end
      if (s_pop) begin
        checks++;
        if (s_inst_pc !== e_pc) begin errors++; $display("[TB] FAIL stop_drain_pc: got %0h expected %0h", s_inst_pc, e_pc); end
      end
    end
    checks++; if (s_qcount !== '0) begin errors++; $display("[TB] FAIL stop_drained: got %0d expected 0", s_qcount); end
    drv_fetch_en = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      cycle_step();
      if (s_accept) begin
        got = 1'b1;
        checks++;
        if (s_req_addr !== RPC) begin errors++; $display("[TB] FAIL restart_addr: got %0h expected %0h", s_req_addr, RPC); end
      end
    end
    checks++; if (!got) begin errors++; $display("[TB] FAIL restart_timeout: got no request expected one"); end
  endtask

`ifdef FETCH_BYPASS_EN
  task automatic test_bypass();
    bit got;
    do_reset();
    drv_fetch_en = 1'b1; drv_req_ready = 1'b1; drv_inst_ready = 1'b1; drv_lat = 1;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      cycle_step();
      if (s_rsp_valid) begin
        got = 1'b1;
        checks++;
        if (s_inst_valid !== 1'b1 || s_inst_pc !== RPC || s_inst_data !== memf(RPC)) begin
          errors++; $display("[TB] FAIL bypass_same_cycle: got valid %0b pc %0h data %0h expected 1 %0h %0h", s_inst_valid, s_inst_pc, s_inst_data, RPC, memf(RPC));
        end
      end
    end
    checks++; if (!got) begin errors++; $display("[TB] FAIL bypass_timeout: got no response expected one"); end
    repeat (6) begin
      cycle_step();
      checks++; if (s_qcount !== '0) begin errors++; $display("[TB] FAIL bypass_q_count: got %0d expected 0", s_qcount); end
    end
  endtask
`endif

  task automatic test_random();
    bit prev_redir;
    do_reset();
    drv_fetch_en = 1'b1;
    prev_redir = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      drv_req_ready  = ($urandom_range(0, 3) != 0);
      drv_inst_ready = ($urandom_range(0, 2) != 0);
      drv_lat        = $urandom_range(1, 4);
      drv_redirect   = ($urandom_range(0, 29) == 0);
      drv_redirect_addr = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
      cycle_step();
      if (s_accept) begin
        checks++;
        if (s_req_addr !== e_addr) begin errors++; $display("[TB] FAIL rnd_addr: got %0h expected %0h", s_req_addr, e_addr); end
      end
      if (s_pop) begin
        checks++;
        if (s_inst_pc !== e_pc || s_inst_data !== e_data) begin
          errors++; $display("[TB] FAIL rnd_pop: got pc %0h data %0h expected pc %0h data %0h", s_inst_pc, s_inst_data, e_pc, e_data);
        end
      end
      checks++; if (s_qcount > CW'(DEPTH)) begin errors++; $display("[TB] FAIL rnd_overflow: got %0d expected <= %0d", s_qcount, DEPTH); end
      if (drv_redirect) begin
        checks++; if (s_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rnd_redir_req: got %0b expected 0", s_req_valid); end
      end
      if (prev_redir) begin
        checks++; if (s_inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rnd_post_redir_valid: got %0b expected 0", s_inst_valid); end
      end
      prev_redir = drv_redirect;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_sequential();
    test_queue_full();
    test_redirect_inflight();
    test_redirect_collision();
    test_stall_wrap();
    test_fetch_stop();
`ifdef FETCH_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
